// File: rtl/detector_colisiones.sv
// detector_colisiones
//   Collision/bonus detector downstream of the obstacle generator. Once per
//   obstacle tick it compares the slot-0 obstacle pattern against the
//   player's 7-segment pattern, tracks lives, detects bonus pickups and
//   reports the game outcome.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   presente[2:0]   top-level FSM state (GAME = playing, WL = result screen)
//   clk_obstaculos  obstacle clock from the generator, sampled as data
//   display_obs[6:0] segment pattern of slot 0 (nearest the player)
//   tipo_obs[4:0]   type of the obstacle entering slot 2
//   jugador[6:0]    player segment pattern
//   mundo[1:0]      current world from the generator
//   W_or_L[1:0]     00 playing, 01 lost, 10 won
//   bono_tomado     high for BONO_HOLD cycles per bonus caught
//   vidas[1:0]      remaining lives
//   golpe           one-clk pulse per counted collision
//
// Build option
//   INMORTAL_EN     collisions still pulse golpe and enter the grace state,
//                   but lives never decrement (board bring-up of late worlds)
module detector_colisiones #(
  parameter int         VIDAS_INI    = 3,
  parameter int         GRACIA_TICKS = 2,
  parameter int         BONO_HOLD    = 1024,
  parameter int         TIPO_BONO    = 16,
  parameter logic [2:0] GAME         = 3'd3,
  parameter logic [2:0] WL           = 3'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] presente,
  input  logic       clk_obstaculos,
  input  logic [6:0] display_obs,
  input  logic [4:0] tipo_obs,
  input  logic [6:0] jugador,
  input  logic [1:0] mundo,
  output logic [1:0] W_or_L,
  output logic       bono_tomado,
  output logic [1:0] vidas,
  output logic       golpe
);

  localparam int BW = $clog2(BONO_HOLD + 1);

  typedef enum logic [2:0] {INACTIVO, JUEGO, GOLPE, PERDIO, GANO} estado_t;

  estado_t         estado, estado_n;
  logic            sync1, sync2, sync3;
  logic            tick, eval;
  logic [4:0]      t2, t1, t0;
  logic [1:0]      vidas_q, vidas_n;
  logic            golpe_q, golpe_n;
  logic [2:0]      gracia, gracia_n;
  logic [BW-1:0]   bono_cnt, bono_cnt_n;
  logic            salir;
  logic            bono_ok, choque;

  // tick is registered so the input edge reaches it in 3 clk; eval follows
  // one clk later, once t0 has shifted and display_obs is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      tick  <= 1'b0;
      eval  <= 1'b0;
    end else begin
      sync1 <= clk_obstaculos;
      sync2 <= sync1;
      sync3 <= sync2;
      tick  <= sync2 & ~sync3;
      eval  <= tick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t2 <= '0;
      t1 <= '0;
      t0 <= '0;
    end else if (salir) begin
      t2 <= '0;
      t1 <= '0;
      t0 <= '0;
    end else if (tick && W_or_L == 2'b00) begin
      t2 <= tipo_obs;
      t1 <= t2;
      t0 <= t1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= INACTIVO;
      vidas_q  <= 2'(VIDAS_INI);
      golpe_q  <= 1'b0;
      gracia   <= '0;
      bono_cnt <= '0;
    end else begin
      estado   <= estado_n;
      vidas_q  <= vidas_n;
      golpe_q  <= golpe_n;
      gracia   <= gracia_n;
      bono_cnt <= bono_cnt_n;
    end
  end

  assign salir   = (estado != INACTIVO) && (presente != GAME) && (presente != WL);
  assign bono_ok = (t0 == 5'(TIPO_BONO)) && (jugador != 7'd0);
  assign choque  = (display_obs & jugador) != 7'd0;

  always_comb begin
    estado_n   = estado;
    vidas_n    = vidas_q;
    golpe_n    = 1'b0;
    gracia_n   = gracia;
    bono_cnt_n = (bono_cnt != '0) ? bono_cnt - 1'b1 : '0;

    if (estado == INACTIVO) begin
      vidas_n    = 2'(VIDAS_INI);
      bono_cnt_n = '0;
      gracia_n   = '0;
      if (presente == GAME)
        estado_n = JUEGO;
    end else if (salir) begin
      estado_n   = INACTIVO;
      vidas_n    = 2'(VIDAS_INI);
      bono_cnt_n = '0;
      gracia_n   = '0;
    end else if (presente == GAME && eval) begin
      case (estado)
        JUEGO: begin
          if (mundo == 2'd3) begin
            estado_n = GANO;
          end else if (bono_ok) begin
            bono_cnt_n = BW'(BONO_HOLD);
          end else if (choque) begin
            golpe_n  = 1'b1;
            estado_n = GOLPE;
            gracia_n = 3'(GRACIA_TICKS);
`ifndef INMORTAL_EN
            if (vidas_q <= 2'd1) begin
              vidas_n  = 2'd0;
              estado_n = PERDIO;
            end else begin
              vidas_n = vidas_q - 2'd1;
            end
`endif
          end
        end
        GOLPE: begin
          if (mundo == 2'd3) begin
            estado_n = GANO;
          end else begin
            if (bono_ok)
              bono_cnt_n = BW'(BONO_HOLD);
            if (gracia <= 3'd1) begin
              gracia_n = '0;
              estado_n = JUEGO;
            end else begin
              gracia_n = gracia - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (estado)
      PERDIO:  W_or_L = 2'b01;
      GANO:    W_or_L = 2'b10;
      default: W_or_L = 2'b00;
    endcase
  end

  assign bono_tomado = (bono_cnt != '0);
  assign vidas       = vidas_q;
  assign golpe       = golpe_q;

endmodule

// File: tb/tb_detector_colisiones.sv
module tb_detector_colisiones;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] presente;
  logic       clk_obstaculos;
  logic [6:0] display_obs;
  logic [4:0] tipo_obs;
  logic [6:0] jugador;
  logic [1:0] mundo;
  logic [1:0] W_or_L;
  logic       bono_tomado;
  logic [1:0] vidas;
  logic       golpe;

  detector_colisiones dut (
    .clk            (clk),
    .rst            (rst),
    .presente       (presente),
    .clk_obstaculos (clk_obstaculos),
    .display_obs    (display_obs),
    .tipo_obs       (tipo_obs),
    .jugador        (jugador),
    .mundo          (mundo),
    .W_or_L         (W_or_L),
    .bono_tomado    (bono_tomado),
    .vidas          (vidas),
    .golpe          (golpe)
  );

  always #5 clk = ~clk;

`ifdef INMORTAL_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  typedef struct {
    logic [2:0] presente;
    logic [6:0] disp;
    logic [4:0] tipo;
    logic [6:0] jug;
    logic [1:0] mundo;
    int         exp_golpes;
    logic [1:0] exp_vidas;
    logic [1:0] exp_wl;
    logic       exp_bono;
  } vec_t;

  vec_t vt[16];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(logic [2:0] p, logic [6:0] d, logic [4:0] t,
                              logic [6:0] j, logic [1:0] m, int g,
                              logic [1:0] v, logic [1:0] w, logic b);
    vec_t r;
    r.presente = p; r.disp = d; r.tipo = t; r.jug = j; r.mundo = m;
    r.exp_golpes = g; r.exp_vidas = v; r.exp_wl = w; r.exp_bono = b;
    return r;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One obstacle tick: drive inputs, raise clk_obstaculos, count golpe pulses.
  task automatic run_vec(input int i);
    int g;
    g = 0;
    @(negedge clk);
    presente = vt[i].presente; display_obs = vt[i].disp; tipo_obs = vt[i].tipo;
    jugador = vt[i].jug; mundo = vt[i].mundo;
    clk_obstaculos = 1'b1;
    repeat (8) begin @(negedge clk); if (golpe) g++; end
    clk_obstaculos = 1'b0;
    repeat (4) begin @(negedge clk); if (golpe) g++; end
    chk($sformatf("v%0d_golpes", i), g, vt[i].exp_golpes);
    chk($sformatf("v%0d_vidas", i), int'(vidas), int'(vt[i].exp_vidas));
    chk($sformatf("v%0d_wl", i), int'(W_or_L), int'(vt[i].exp_wl));
    chk($sformatf("v%0d_bono", i), int'(bono_tomado), int'(vt[i].exp_bono));
  endtask

  initial begin
    int g, hi, w;
    bit seen;

    vt[0]  = mk(3'd3, 7'h00, 5'd0,  7'h08, 2'd0, 0, 2'd3, 2'b00, 1'b0);
    vt[1]  = mk(3'd3, 7'h08, 5'd0,  7'h08, 2'd0, 1, IMM ? 2'd3 : 2'd2, 2'b00, 1'b0);
    vt[2]  = mk(3'd3, 7'h08, 5'd0,  7'h08, 2'd0, 0, IMM ? 2'd3 : 2'd2, 2'b00, 1'b0);
    vt[3]  = mk(3'd3, 7'h08, 5'd0,  7'h08, 2'd0, 0, IMM ? 2'd3 : 2'd2, 2'b00, 1'b0);
    vt[4]  = mk(3'd3, 7'h08, 5'd0,  7'h08, 2'd0, 1, IMM ? 2'd3 : 2'd1, 2'b00, 1'b0);
    vt[5]  = mk(3'd3, 7'h00, 5'd0,  7'h08, 2'd0, 0, IMM ? 2'd3 : 2'd1, 2'b00, 1'b0);
    vt[6]  = mk(3'd3, 7'h00, 5'd0,  7'h08, 2'd0, 0, IMM ? 2'd3 : 2'd1, 2'b00, 1'b0);
    vt[7]  = mk(3'd3, 7'h08, 5'd0,  7'h08, 2'd0, 1, IMM ? 2'd3 : 2'd0, IMM ? 2'b00 : 2'b01, 1'b0);
    vt[8]  = mk(3'd4, 7'h08, 5'd0,  7'h08, 2'd0, 0, IMM ? 2'd3 : 2'd0, IMM ? 2'b00 : 2'b01, 1'b0);
    vt[9]  = mk(3'd0, 7'h08, 5'd0,  7'h08, 2'd0, 0, 2'd3, 2'b00, 1'b0);
    vt[10] = mk(3'd3, 7'h00, 5'd16, 7'h40, 2'd0, 0, 2'd3, 2'b00, 1'b0);
    vt[11] = mk(3'd3, 7'h00, 5'd0,  7'h40, 2'd0, 0, 2'd3, 2'b00, 1'b0);
    vt[12] = mk(3'd3, 7'h40, 5'd0,  7'h40, 2'd3, 0, 2'd3, 2'b10, 1'b0);
    vt[13] = mk(3'd4, 7'h40, 5'd0,  7'h40, 2'd3, 0, 2'd3, 2'b10, 1'b0);
    vt[14] = mk(3'd0, 7'h00, 5'd0,  7'h40, 2'd0, 0, 2'd3, 2'b00, 1'b0);
    vt[15] = mk(3'd3, 7'h08, 5'd0,  7'h08, 2'd0, 1, IMM ? 2'd3 : 2'd2, 2'b00, 1'b0);

    rst = 1'b1; presente = 3'd0; clk_obstaculos = 1'b0; display_obs = '0;
    tipo_obs = '0; jugador = '0; mundo = '0;
    repeat (3) @(negedge clk);
    chk("rst_vidas", int'(vidas), 3);
    chk("rst_wl", int'(W_or_L), 0);
    chk("rst_bono", int'(bono_tomado), 0);
    chk("rst_golpe", int'(golpe), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i <= 11; i++) run_vec(i);

    // Third tick after the bonus type entered slot 2: bonus wins over overlap.
    @(negedge clk);
    presente = 3'd3; tipo_obs = 5'd0; jugador = 7'h40; display_obs = 7'h40; mundo = 2'd0;
    clk_obstaculos = 1'b1;
    g = 0; seen = 1'b0; w = 0;
    while (!seen && w < 20) begin
      @(negedge clk); w++;
      if (golpe) g++;
      if (bono_tomado) seen = 1'b1;
    end
    chk("bono_rise", int'(seen), 1);
    clk_obstaculos = 1'b0;
    display_obs = 7'h00;
    hi = seen ? 1 : 0;
    while (seen && bono_tomado && hi < 2000) begin
      @(negedge clk);
      if (golpe) g++;
      if (bono_tomado) hi++;
    end
    chk("bono_len", hi, 1024);
    chk("bono_golpes", g, 0);

    for (int i = 12; i <= 15; i++) run_vec(i);

    // Asynchronous reset mid-game takes effect without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_vidas", int'(vidas), 3);
    chk("arst_wl", int'(W_or_L), 0);
    chk("arst_bono", int'(bono_tomado), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/detector_colisiones.md
Name: detector_colisiones

Overview:
- Downstream consumer of the obstacle generator.
- Compares the obstacle pattern in the slot nearest the player (display_obs[6:0]) against the player's 7-segment pattern, once per obstacle tick.
- Tracks lives, detects the bonus reaching the player, and produces W_or_L for the generator and the top-level state machine.
- Produces the bono_tomado level that advances the generator's world counter.

Parameters:
- VIDAS_INI, 3: lives at the start of a game (1..3).
- GRACIA_TICKS, 2: obstacle ticks of invulnerability after a hit (1..7).
- BONO_HOLD, 1024: clk cycles bono_tomado stays high per bonus (>=4).
- TIPO_BONO, 16: tipo_obs code that marks a bonus.
- GAME, 3'd3: presente code for in-game.
- WL, 3'd4: presente code for the win/lose screen.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- presente, in, 3: top-level FSM state.
- clk_obstaculos, in, 1: obstacle clock from the generator; sampled as data.
- display_obs, in, 7: segment pattern of slot 0 (nearest player).
- tipo_obs, in, 5: type of the obstacle entering slot 2.
- jugador, in, 7: player segment pattern.
- mundo, in, 2: current world from the generator.
- W_or_L, out, 2: 00 playing, 01 lost, 10 won.
- bono_tomado, out, 1: high for BONO_HOLD cycles per bonus caught.
- vidas, out, 2: remaining lives.
- golpe, out, 1: one-clk pulse on each counted collision.

Behaviour:
- Reset (async, rst=1): state INACTIVO, W_or_L=00, bono_tomado=0, vidas=VIDAS_INI, golpe=0, type pipeline cleared to 0, synchronizer flops 0, all counters 0.
- Tick generation: clk_obstaculos passes through a 2-flop synchronizer. A rising edge on the synchronized signal gives tick, one clk wide. Latency from the input edge to tick is 3 clk.
- Type pipeline:
  - 3 entries, t2 -> t1 -> t0, shifted on tick.
  - On tick: t2<=tipo_obs, t1<=t2, t0<=t1. This mirrors the generator's 3-slot shift, so t0 is the type of the object in slot 0.
  - The pipeline freezes while W_or_L != 00.
- Evaluation point: one clk after tick (eval), so the shifted t0 and a stable display_obs are used.
- States:
  - INACTIVO:
    - Outputs are the reset values, except vidas holds VIDAS_INI.
    - Go to JUEGO when presente==GAME.
  - JUEGO, at eval:
    - Priority 1: if mundo==3, go to GANO.
    - Priority 2: else if t0==TIPO_BONO and jugador!=0, start the bonus (bono_tomado=1, load BONO_HOLD counter). No collision check that tick.
    - Priority 3: else if (display_obs & jugador)!=0:
      - golpe pulses.
      - vidas decrements.
      - If the new vidas==0, go to PERDIO.
      - Otherwise go to GOLPE with the grace counter=GRACIA_TICKS.
  - GOLPE:
    - Collisions are ignored.
    - The bonus still works, same rule as JUEGO.
    - The grace counter decrements on each eval; at 0, return to JUEGO.
    - If mundo==3, go to GANO.
  - PERDIO: W_or_L=01; held.
  - GANO: W_or_L=10; held.
- Exit from any state except INACTIVO: if presente is neither GAME nor WL, go to INACTIVO, vidas=VIDAS_INI, and clear the pipeline.
- presente==WL holds the current state and outputs.
- bono_tomado:
  - The counter decrements every clk; bono_tomado drops when it reaches 0.
  - A new bonus while high reloads the counter. The signal stays high, so the generator sees a single rising edge.
  - Forced to 0 on entry to INACTIVO.
- vidas saturates at 0; never underflows.
- Simultaneous events: rst dominates everything. Leaving GAME/WL dominates tick processing. mundo==3 dominates a collision in the same eval.

Optional Feature:
- Macro INMORTAL_EN.
- Defined: collisions still pulse golpe and enter GOLPE, but vidas never decrements and PERDIO is unreachable. Used for board bring-up of later worlds.
- Undefined: behaviour as above.

Test Plan:
- rst=1 mid-game with vidas=1 -> immediately W_or_L=00, vidas=3, bono_tomado=0, state INACTIVO.
- presente=3, jugador=7'h08, display_obs=7'h08 on one tick -> golpe pulses once ~4 clk after the clk_obstaculos edge, vidas 3->2. The same overlap on the next 2 ticks -> vidas stays 2 (grace); on the 3rd tick -> 1.
- Three separate collisions outside grace -> vidas 3,2,1,0; W_or_L=01 and held while presente=4; presente=0 -> W_or_L=00, vidas=3.
- tipo_obs=16 sampled on tick n, jugador=7'h40 -> bono_tomado rises after eval of tick n+2 and stays high exactly 1024 clk. No golpe even if display_obs overlaps on that tick.
- mundo=3 while in JUEGO -> W_or_L=10 at the next eval. A simultaneous overlapping obstacle gives no golpe and vidas unchanged.
- INMORTAL_EN defined, 5 collisions -> 5 golpe pulses, vidas=3, W_or_L stays 00.
